trng_vn_packer: RTL
===================

Name: trng_vn_packer

Overview:
- Downstream consumer of the TRNG sampling register.
- Takes each enabled sample vector and XOR-reduces it to one raw bit.
- Removes bias with a von Neumann corrector and packs corrected bits into WORD_W-bit words.
- Presents words on a valid/ready interface to the bus/FIFO side.

Parameters:
- NBITS, 8, width of the sampled vector from the sampling register.
- WORD_W, 32, output word width; legal range 2..64.
- RCT_CUTOFF, 32, repetition-count threshold for the optional health test; legal range 2..255.

Ports:
- clk  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- en_i  in  1  block enable; low clears pairing state and the partial word.
- sample_i  in  NBITS  sampled vector from the sampling register.
- sample_valid_i  in  1  sample_i holds a new sample this cycle (same strobe as the register enable, delayed one cycle).
- word_o  out  WORD_W  packed random word.
- word_valid_o  out  1  word_o is valid.
- word_ready_i  in  1  consumer accepts word_o.
- overflow_o  out  1  sticky: a corrected bit was dropped because no storage was free.
- rct_alarm_o  out  1  sticky: repetition-count health test failed.
- clr_i  in  1  synchronous clear of overflow_o and rct_alarm_o.

Behaviour:
- Reset (async, rst_ni low):
  - word_o=0, word_valid_o=0, overflow_o=0, rct_alarm_o=0.
  - Pair FSM in IDLE, pack count=0, accumulator=0, RCT count=0.
- Raw bit: raw = XOR of all sample_i bits. It is consumed only when en_i && sample_valid_i.
- Pair FSM:
  - IDLE: on consume, store raw as "first" and go to HALF.
  - HALF: on consume, compare raw with first.
    - Differ (01 or 10): emit corrected bit = first (01→0, 10→1).
    - Equal (00 or 11): emit nothing.
    - Either way return to IDLE.
- Packer:
  - Accumulator acc[WORD_W-2:0] and count cnt, width clog2(WORD_W).
  - On emit with cnt < WORD_W-1: acc shifts left, emitted bit enters the LSB, cnt+1.
  - On emit with cnt == WORD_W-1 (completing bit):
    - If the output slot is free (word_valid_o=0) or is being drained this cycle (word_valid_o && word_ready_i): next cycle word_o={acc,bit}, word_valid_o=1, cnt=0.
    - Otherwise: drop the bit, set overflow_o, leave acc/cnt unchanged.
- Latency: the completing corrected bit (second sample of its pair) is visible on word_o one cycle after its sample_valid_i.
- Handshake:
  - A transfer occurs when word_valid_o && word_ready_i.
  - word_o and word_valid_o stay stable while valid && !ready.
  - Transfer with no new word loading: word_valid_o→0 next cycle; word_o keeps its last value.
  - Transfer and new-word load in the same cycle: word_valid_o stays 1, word_o takes the new word, with no bubble.
- en_i low:
  - Pair FSM→IDLE, cnt=0, acc=0 on the next edge.
  - A pending word_o/word_valid_o is kept and can still be transferred.
  - The RCT count is cleared.
- Sticky flags:
  - clr_i clears overflow_o and rct_alarm_o.
  - If clr_i and a set event coincide, set wins.
- Mid-pair disable: the held first bit is discarded; no partial pair ever survives en_i low.

Optional Feature:
- Macro: TRNG_RCT_EN.
- Defined:
  - Repetition-count test on consumed raw bits (before debiasing).
  - Count is 8 bits. It loads 1 on a raw bit that differs from the previous one and increments, saturating, on an equal one.
  - When the count reaches RCT_CUTOFF: set rct_alarm_o, clear the pair FSM, cnt and acc the next cycle (partial word discarded), and reload the count to 1.
  - A pending word_o is not affected.
- Not defined: rct_alarm_o is tied to 0, RCT_CUTOFF is unused, and no RCT logic is present.

Test Plan (WORD_W=8, NBITS=4):
- Reset values: apply rst_ni low mid-cycle → all outputs 0 immediately (async), no word emitted afterwards without samples.
- Packing: feed raw pairs 10,01,10,10,01,01,10,01 (samples 4'b0001/4'b0000 etc.), word_ready_i=1 → word_o=8'b10110010, word_valid_o high exactly one cycle after the 16th sample.
- Discarding pairs: interleave 00 and 11 pairs between the above → same word 8'b10110010, with the valid strobe delayed accordingly.
- Backpressure: word_ready_i=0, produce two full words → first word held stable; the 16th corrected bit is dropped and overflow_o=1; raise ready → the first word transfers, overflow_o stays 1 until clr_i.
- Disable mid-pair: after a single raw 1, pulse en_i low one cycle, then feed 0,1 → emitted bit is 0 (the new pair 01), not derived from the stale 1.
- With TRNG_RCT_EN and RCT_CUTOFF=4: feed raw 1,1,1,1 → rct_alarm_o=1 after the 4th sample, cnt reset; clr_i → 0. Without the macro, the same stimulus keeps rct_alarm_o=0.

Source files
------------

// File: rtl/trng_vn_packer_if.sv
// trng_vn_packer_if: valid/ready word channel from the packer to the bus/FIFO side.
interface trng_vn_packer_if #(
  parameter int WORD_W = 32
);
  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              word_ready_i;
  modport master (output word_o, word_valid_o, input word_ready_i);
  modport slave  (input word_o, word_valid_o, output word_ready_i);
endinterface

// File: rtl/trng_vn_packer.sv
// trng_vn_packer: XOR-reduce samples, von Neumann debias, pack into WORD_W-bit words.
// Define TRNG_RCT_EN to add the repetition-count health test on raw bits.
module trng_vn_packer #(
  parameter int NBITS      = 8,
  parameter int WORD_W     = 32,
  parameter int RCT_CUTOFF = 32
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [NBITS-1:0] sample_i,
  input  logic             sample_valid_i,
  input  logic             clr_i,
  output logic             overflow_o,
  output logic             rct_alarm_o,
  trng_vn_packer_if.master word_if
);
  localparam int AW = WORD_W - 1;
  localparam int CW = $clog2(WORD_W);
  typedef enum logic {IDLE, HALF} pair_t;
  pair_t state, state_n;
  logic first, raw, consume, trip, emit, full, slot_free, load;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  assign raw       = ^sample_i;
  assign consume   = en_i && sample_valid_i;
  assign full      = cnt == CW'(AW);
  assign slot_free = !word_if.word_valid_o || word_if.word_ready_i;
  assign load      = emit && full && slot_free;
`ifdef TRNG_RCT_EN
  logic [7:0] rct_cnt, rct_cnt_n;
  logic       rct_prev;
  // a count of 0 means no previous raw bit since reset/disable
  assign rct_cnt_n = (rct_cnt == 8'd0 || raw != rct_prev) ? 8'd1 :
                     (rct_cnt == 8'hff) ? rct_cnt : rct_cnt + 8'd1;
  assign trip      = consume && rct_cnt_n == 8'(RCT_CUTOFF);
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      rct_cnt     <= 8'd0;
      rct_prev    <= 1'b0;
      rct_alarm_o <= 1'b0;
    end else begin
      rct_cnt     <= !en_i ? 8'd0 : trip ? 8'd1 : consume ? rct_cnt_n : rct_cnt;
      rct_prev    <= consume ? raw : rct_prev;
      rct_alarm_o <= trip || (rct_alarm_o && !clr_i);
    end
  end
`else
  assign trip        = 1'b0;
  assign rct_alarm_o = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      first <= 1'b0;
    end else begin
      state <= state_n;
      first <= (consume && state == IDLE) ? raw : first;
    end
  end
  always_comb begin
    state_n = state;
    emit    = 1'b0;
    if (consume && !trip) begin
      state_n = (state == IDLE) ? HALF : IDLE;
      emit    = (state == HALF) && (raw != first);
    end
    if (!en_i || trip) state_n = IDLE;
  end
  // the corrected bit of a differing pair is the held first bit
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      acc                  <= '0;
      cnt                  <= '0;
      word_if.word_o       <= '0;
      word_if.word_valid_o <= 1'b0;
      overflow_o           <= 1'b0;
    end else begin
      if (!en_i || trip || load) begin
        acc <= '0;
        cnt <= '0;
      end else if (emit && !full) begin
        acc <= AW'({acc, first});
        cnt <= cnt + 1'b1;
      end
      if (load) word_if.word_o <= {acc, first};
      word_if.word_valid_o <= load || (word_if.word_valid_o && !word_if.word_ready_i);
      overflow_o           <= (emit && full && !slot_free) || (overflow_o && !clr_i);
    end
  end
endmodule
